// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: opcodes, NZCV flag struct and arbiter states.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package alu_arb_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_EOR = 4'b0001;
    localparam alu_op_t ALU_SUB = 4'b0010;
    localparam alu_op_t ALU_RSB = 4'b0011;
    localparam alu_op_t ALU_ADD = 4'b0100;
    localparam alu_op_t ALU_ADC = 4'b0101;
    localparam alu_op_t ALU_SBC = 4'b0110;
    localparam alu_op_t ALU_RSC = 4'b0111;
    localparam alu_op_t ALU_TST = 4'b1000;
    localparam alu_op_t ALU_TEQ = 4'b1001;
    localparam alu_op_t ALU_CMP = 4'b1010;
    localparam alu_op_t ALU_CMN = 4'b1011;
    localparam alu_op_t ALU_ORR = 4'b1100;
    localparam alu_op_t ALU_MOV = 4'b1101;
    localparam alu_op_t ALU_BIC = 4'b1110;
    localparam alu_op_t ALU_NOT = 4'b1111;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // Index width for 2..4 requesters.
    function automatic int idx_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// One-hot requester picker: round-robin after last_grant, or lowest index wins
// when ALU_ARB_FIXED_PRIO_EN is defined (last_grant port then disappears).
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]              req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [idx_width(NREQ)-1:0]   last_grant,
`endif
    output logic [NREQ-1:0]              grant
);

    logic found;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // First pass looks above last_grant, second pass wraps to the bottom.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i > int'(last_grant))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters and owns the NZCV register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*4-1:0]   req_op,
    input  logic [NREQ*W-1:0]   req_rn,
    input  logic [NREQ*W-1:0]   req_src2,
    input  logic [NREQ-1:0]     req_setf,
    output logic [NREQ-1:0]     resp_valid,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [W-1:0]        resp_rd,
    output logic [3:0]          resp_flags,
    output logic [3:0]          flags_q,
    output logic [W-1:0]        alu_rn,
    output logic [W-1:0]        alu_src2,
    output logic [3:0]          alu_ctrl,
    input  logic [W-1:0]        alu_rd,
    input  logic [3:0]          alu_flags,
    output logic                busy
);

    localparam int IDXW = idx_width(NREQ);

    arb_state_t        state;
    logic [IDXW-1:0]   grant_idx;
    logic [NREQ-1:0]   pick;
    logic [IDXW-1:0]   win_idx;
    alu_op_t           sel_op;
    logic [W-1:0]      sel_rn;
    logic [W-1:0]      sel_src2;
    logic              sel_setf;

    alu_op_t           op_q;
    logic [W-1:0]      rn_q;
    logic [W-1:0]      src2_q;
    logic              setf_q;
    logic [NREQ-1:0]   resp_valid_r;
    logic [W-1:0]      resp_rd_r;
    nzcv_t             resp_flags_r;
    nzcv_t             flags_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]   last_grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Reset value makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDXW'(NREQ - 1);
        end else if (state == IDLE && |pick) begin
            last_grant <= win_idx;
        end
    end
`else
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .grant (pick)
    );
`endif

    // Encode the winner and mux out its operation fields.
    always_comb begin
        win_idx  = '0;
        sel_op   = ALU_AND;
        sel_rn   = '0;
        sel_src2 = '0;
        sel_setf = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                win_idx  = IDXW'(i);
                sel_op   = req_op[i*4 +: 4];
                sel_rn   = req_rn[i*W +: W];
                sel_src2 = req_src2[i*W +: W];
                sel_setf = req_setf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_idx    <= '0;
            op_q         <= ALU_AND;
            rn_q         <= '0;
            src2_q       <= '0;
            setf_q       <= 1'b0;
            resp_valid_r <= '0;
            resp_rd_r    <= '0;
            resp_flags_r <= '0;
            flags_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        op_q      <= sel_op;
                        rn_q      <= sel_rn;
                        src2_q    <= sel_src2;
                        setf_q    <= sel_setf;
                        grant_idx <= win_idx;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_rd_r    <= alu_rd;
                    resp_flags_r <= nzcv_t'(alu_flags);
                    if (setf_q) begin
                        flags_r <= nzcv_t'(alu_flags);
                    end
                    resp_valid_r <= NREQ'(1) << grant_idx;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready[grant_idx]) begin
                        resp_valid_r <= '0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // The op registers double as the ALU drive so the operands hold outside EXEC.
    assign alu_rn     = rn_q;
    assign alu_src2   = src2_q;
    assign alu_ctrl   = op_q;

    assign req_ready  = (state == IDLE) ? pick : '0;
    assign resp_valid = resp_valid_r;
    assign resp_rd    = resp_rd_r;
    assign resp_flags = resp_flags_r;
    assign flags_q    = flags_r;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a transaction-timing reference model
// and a stand-in ALU; honours ALU_ARB_FIXED_PRIO_EN in its expectations.
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_setf, resp_valid, resp_ready;
    logic [NREQ*4-1:0] req_op;
    logic [NREQ*W-1:0] req_rn, req_src2;
    logic [W-1:0]      resp_rd, alu_rn, alu_src2, alu_rd;
    logic [3:0]        resp_flags, flags_q, alu_ctrl, alu_flags;
    logic              busy;

    logic [2:0]        req_valid3, req_ready3, req_setf3, resp_valid3, resp_ready3;
    logic [11:0]       req_op3;
    logic [3*W-1:0]    req_rn3, req_src23;
    logic [W-1:0]      resp_rd3, alu_rn3, alu_src23, alu_rd3;
    logic [3:0]        resp_flags3, flags_q3, alu_ctrl3, alu_flags3;
    logic              busy3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit          m_out;
    int          m_owner;
    int          m_t0;
    logic [35:0] m_res;
    bit          m_setf;
    logic [3:0]  m_flags;
    int          m_last;
    int          acc_cyc[$];
    int          acc_idx[$];
    logic [NREQ-1:0] seen_ready;

    // Stand-in ALU: returns {Rd, N, Z, C, V}; C is carry for adds and borrow for subtracts.
    function automatic logic [35:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            ALU_AND: r = a & b;
            ALU_EOR: r = a ^ b;
            ALU_SUB, ALU_CMP: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_ADD, ALU_CMN: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_ORR: r = a | b;
            ALU_MOV: r = b;
            ALU_BIC: r = a & ~b;
            default: r = ~b;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    assign {alu_rd, alu_flags}   = aluModel(alu_ctrl, alu_rn, alu_src2);
    assign {alu_rd3, alu_flags3} = aluModel(alu_ctrl3, alu_rn3, alu_src23);

    alu_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rn(req_rn), .req_src2(req_src2), .req_setf(req_setf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_flags(resp_flags), .flags_q(flags_q),
        .alu_rn(alu_rn), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_rd(alu_rd), .alu_flags(alu_flags), .busy(busy)
    );

    alu_share_arb #(.NREQ(3), .W(W)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_rn(req_rn3), .req_src2(req_src23), .req_setf(req_setf3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rd(resp_rd3),
        .resp_flags(resp_flags3), .flags_q(flags_q3),
        .alu_rn(alu_rn3), .alu_src2(alu_src23), .alu_ctrl(alu_ctrl3),
        .alu_rd(alu_rd3), .alu_flags(alu_flags3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [3:0] op,
                                 input logic [31:0] rn, input logic [31:0] src2, input logic setf);
        req_valid[i]        = v;
        req_op[i*4 +: 4]    = op;
        req_rn[i*W +: W]    = rn;
        req_src2[i*W +: W]  = src2;
        req_setf[i]         = setf;
    endtask

    function automatic int pickWinner(input logic [NREQ-1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic modelReset();
        m_out   = 1'b0;
        m_flags = 4'd0;
        m_last  = NREQ - 1;
    endtask

    // Accept at T, result visible from T+2 until the owner takes it; free again the cycle after.
    task automatic checkCycle();
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        bit              exp_busy;
        int              w;
        exp_ready = '0;
        exp_rv    = '0;
        w         = -1;
        exp_busy  = m_out && (cyc > m_t0);
        if (!m_out) begin
            w = pickWinner(req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end else if (cyc >= m_t0 + 2) begin
            exp_rv[m_owner] = 1'b1;
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("resp_valid", 64'(resp_valid), 64'(exp_rv));
        checkOutput("busy", 64'(busy), 64'(exp_busy));
        checkOutput("flags_q", 64'(flags_q), 64'(m_flags));
        if (exp_rv != '0) begin
            checkOutput("resp_rd", 64'(resp_rd), 64'(m_res[35:4]));
            checkOutput("resp_flags", 64'(resp_flags), 64'(m_res[3:0]));
        end
        seen_ready = req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                acc_cyc.push_back(cyc);
                acc_idx.push_back(i);
            end
        end
        if (w >= 0) begin
            m_out   = 1'b1;
            m_owner = w;
            m_t0    = cyc;
            m_res   = aluModel(req_op[w*4 +: 4], req_rn[w*W +: W], req_src2[w*W +: W]);
            m_setf  = req_setf[w];
            m_last  = w;
        end else if (m_out && cyc == m_t0 + 1) begin
            if (m_setf) m_flags = m_res[3:0];
        end else if (m_out && cyc >= m_t0 + 2 && resp_ready[m_owner]) begin
            m_out = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = '1;
        for (int n = 0; n < 8 && m_out; n++) step();
        checkOutput("drain_busy", 64'(busy), 64'(0));
    endtask

    task automatic run3(input string tag, input logic [2:0] v, input logic [2:0] exp_oh,
                        input logic [31:0] exp_rd);
        req_valid3 = v;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 64'(req_ready3), 64'(exp_oh));
        @(posedge clk);
        #1;
        req_valid3 = '0;
        checkOutput({tag, "_busy"}, 64'(busy3), 64'(1));
        @(posedge clk);
        #1;
        checkOutput({tag, "_rv"}, 64'(resp_valid3), 64'(exp_oh));
        checkOutput({tag, "_rd"}, 64'(resp_rd3), 64'(exp_rd));
        checkOutput({tag, "_fl"}, 64'(resp_flags3), 64'(aluModel(ALU_MOV, 32'd0, exp_rd) & 36'hF));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randVal();
        case ($urandom_range(4))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [35:0] hold_exp;
        int          base;
        int          hs_cyc;

        rst_n = 1'b1;
        req_valid = '0; req_op = '0; req_rn = '0; req_src2 = '0; req_setf = '0;
        resp_ready = '0; seen_ready = '0;
        req_valid3 = '0; req_setf3 = '0; resp_ready3 = '1;
        req_op3 = {ALU_MOV, ALU_MOV, ALU_MOV};
        req_rn3 = '0;
        req_src23 = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
        modelReset();
        #1 rst_n = 1'b0;
        #11;
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_resp_rd", 64'(resp_rd), 64'(0));
        checkOutput("rst_resp_flags", 64'(resp_flags), 64'(0));
        checkOutput("rst_flags_q", 64'(flags_q), 64'(0));
        checkOutput("rst_alu", 64'({alu_rn, alu_src2}), 64'(0));
        checkOutput("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed ADD overflow on req0");
        resp_ready = '1;
        applyStimulus(0, 1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        step();
        checkOutput("add_grant", 64'(acc_idx[$]), 64'(0));
        req_valid = '0;
        step();
        checkOutput("add_rv", 64'(resp_valid), 64'(2'b01));
        checkOutput("add_rd", 64'(resp_rd), 64'h8000_0000);
        checkOutput("add_flags", 64'(resp_flags), 64'(4'b1001));
        checkOutput("add_flags_q", 64'(flags_q), 64'(4'b1001));
        step();

        $display("[TB] directed SUB without flag update on req1");
        applyStimulus(1, 1'b1, ALU_SUB, 32'd5, 32'd5, 1'b0);
        step();
        req_valid = '0;
        step();
        checkOutput("sub_rv", 64'(resp_valid), 64'(2'b10));
        checkOutput("sub_rd", 64'(resp_rd), 64'(0));
        checkOutput("sub_flags", 64'(resp_flags), 64'(4'b0100));
        checkOutput("sub_flags_q", 64'(flags_q), 64'(4'b1001));
        step();

        $display("[TB] both requesters saturating");
        applyStimulus(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
        applyStimulus(1, 1'b1, ALU_SUB, 32'd9, 32'd3, 1'b1);
        base = acc_idx.size();
        repeat (18) step();
        drain();
        checkOutput("sat_count", 64'(acc_idx.size() - base), 64'(6));
        if (acc_idx.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                checkOutput("sat_grant", 64'(acc_idx[base+k]), 64'(0));
`else
                checkOutput("sat_grant", 64'(acc_idx[base+k]), 64'(k % 2));
`endif
                checkOutput("sat_spacing", 64'(acc_cyc[base+k] - acc_cyc[base]), 64'(3 * k));
            end
        end

        $display("[TB] response back-pressure on req0");
        resp_ready = 2'b10;
        applyStimulus(0, 1'b1, ALU_ORR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1);
        step();
        req_valid[0] = 1'b0;
        applyStimulus(1, 1'b1, ALU_AND, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        step();
        hold_exp = aluModel(ALU_ORR, 32'hF0F0_0000, 32'h0000_0F0F);
        for (int k = 0; k < 4; k++) begin
            checkOutput("hold_rv", 64'(resp_valid), 64'(2'b01));
            checkOutput("hold_rd", 64'(resp_rd), 64'(hold_exp[35:4]));
            checkOutput("hold_flags", 64'(resp_flags), 64'(hold_exp[3:0]));
            step();
        end
        resp_ready = 2'b01;
        step();
        hs_cyc = cyc - 1;
        step();
        checkOutput("hold_next_grant", 64'(acc_idx[$]), 64'(1));
        checkOutput("hold_next_cycle", 64'(acc_cyc[$] - hs_cyc), 64'(1));
        drain();

        $display("[TB] reset during EXEC");
        applyStimulus(0, 1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        step();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("abort_rv", 64'(resp_valid), 64'(0));
        checkOutput("abort_flags_q", 64'(flags_q), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();
        req_valid = '1;
        step();
        checkOutput("post_reset_grant", 64'(acc_idx[$]), 64'(0));
        drain();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !seen_ready[i]) begin
                    if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
                end else begin
                    applyStimulus(i, 1'($urandom_range(1)), 4'($urandom), randVal(), randVal(),
                                  1'($urandom_range(1)));
                end
            end
            resp_ready = NREQ'($urandom);
            step();
        end
        drain();

        $display("[TB] three-requester wrap search");
        run3("n3_first", 3'b001, 3'b001, 32'h0000_0100);
        run3("n3_wrap", 3'b100, 3'b100, 32'h0000_0102);
        run3("n3_after", 3'b101, 3'b001, 32'h0000_0100);
        checkOutput("n3_flags_q", 64'(flags_q3), 64'(0));
        checkOutput("n3_idle", 64'({busy3, resp_valid3}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
